// File: rtl/pushbutton_conditioner_if.sv
// ----------------------------------------------------------------------------
// pushbutton_conditioner_if
//   Groups the board-pin and uP-facing signals of the pushbutton conditioner.
//   master : the environment (board pins + uP) that drives raw levels and the
//            read strobe, and consumes the conditioned outputs.
//   slave  : the conditioner itself.
// Signals
//   buttons_raw  [WIDTH] asynchronous button levels from the pins
//   rd_strobe    [1]     1-cycle pulse from the uP; clears the pressed flags
//   pushbuttons  [WIDTH] debounced levels, drives uP.pushbuttons
//   pressed      [WIDTH] sticky per-button press flags
//   changed      [1]     1-cycle pulse when any debounced bit changes
// ----------------------------------------------------------------------------
interface pushbutton_conditioner_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] buttons_raw;
    logic             rd_strobe;
    logic [WIDTH-1:0] pushbuttons;
    logic [WIDTH-1:0] pressed;
    logic             changed;

    modport master (
        output buttons_raw,
        output rd_strobe,
        input  pushbuttons,
        input  pressed,
        input  changed
    );

    modport slave (
        input  buttons_raw,
        input  rd_strobe,
        output pushbuttons,
        output pressed,
        output changed
    );
endinterface

// File: rtl/pushbutton_conditioner.sv
// ----------------------------------------------------------------------------
// pushbutton_conditioner
//   Input stage in front of the uP pushbuttons port. Each raw button bit is
//   passed through a 2-FF synchroniser and then debounced independently: a new
//   level is accepted only after it has differed from the current debounced
//   level on DEBOUNCE_CYCLES consecutive rising edges. Sticky press flags record
//   debounced 0->1 transitions until the uP clears them with rd_strobe.
//
// Parameters
//   WIDTH            number of buttons
//   DEBOUNCE_CYCLES  consecutive differing edges needed to accept a level (>= 2)
//
// Ports
//   clock   in  system clock, rising edge
//   reset   in  asynchronous active-low reset, clears all state
//   pb_bus  slave modport of pushbutton_conditioner_if
//             buttons_raw / rd_strobe in, pushbuttons / pressed / changed out
//
// Configuration macro
//   PB_EDGE_LATCH_EN  defined   : pressed flags built, cleared by rd_strobe
//                     undefined : pressed tied to 0, rd_strobe ignored
//
// All outputs come straight from flops; there is no input-to-output
// combinational path.
// ----------------------------------------------------------------------------
module pushbutton_conditioner #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    pushbutton_conditioner_if.slave pb_bus
);
    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0] pb_q;
    logic [WIDTH-1:0] flip;
    logic [WIDTH-1:0] rise;
    logic             changed_q;

    // ---- stage p0/p1: two-flop synchroniser per bit ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= pb_bus.buttons_raw;
            sync_p1 <= sync_p0;
        end
    end

    // A bit flips on the edge where it has already differed for
    // DEBOUNCE_CYCLES-1 edges and still differs, i.e. the DEBOUNCE_CYCLES-th.
    always_comb begin
        flip = '0;
        for (int i = 0; i < WIDTH; i++) begin
            flip[i] = (sync_p1[i] != pb_q[i]) && (cnt[i] == CNT_MAX);
        end
    end

    // Only debounced 0->1 transitions count as presses.
    assign rise = flip & sync_p1;

    // ---- debounce stage: per-bit persistence counters ----
    for (genvar g = 0; g < WIDTH; g++) begin : g_debounce
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                cnt[g] <= '0;
            end else if ((sync_p1[g] == pb_q[g]) || flip[g]) begin
                // Matching level or just accepted: restart the count.
                cnt[g] <= '0;
            end else begin
                cnt[g] <= cnt[g] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pb_q      <= '0;
            changed_q <= 1'b0;
        end else begin
            pb_q      <= pb_q ^ flip;
            // Single pulse regardless of how many bits flip together.
            changed_q <= |flip;
        end
    end

    assign pb_bus.pushbuttons = pb_q;
    assign pb_bus.changed     = changed_q;

`ifdef PB_EDGE_LATCH_EN
    logic [WIDTH-1:0] pressed_q;

    // Set has priority over the read-strobe clear so a press landing on the
    // same edge as the uP read is never lost.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pressed_q <= '0;
        end else if (pb_bus.rd_strobe) begin
            pressed_q <= rise;
        end else begin
            pressed_q <= pressed_q | rise;
        end
    end

    assign pb_bus.pressed = pressed_q;
`else
    // Feature disabled: rd_strobe and the rise vector intentionally go nowhere.
    logic unused_rd;
    assign unused_rd      = pb_bus.rd_strobe ^ (^rise);
    assign pb_bus.pressed = '0;
`endif

endmodule
